// File: rtl/aes_pkg.sv
// Shared AES-128 tables, GF(2^8) helpers, state layout and FSM encoding for the iterative engine.
package aes_pkg;

    // [col][row]; element [0][0] is the MSB byte, so a 128-bit block casts straight across.
    typedef logic [0:3][0:3][7:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } aes_fsm_e;

    localparam logic [3:0] NR = 4'd10;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:10][7:0] RCON = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] n);
        return (n <= NR) ? RCON[n] : 8'h00;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic aes_state_t unpack_state(input logic [127:0] blk);
        return aes_state_t'(blk);
    endfunction

    function automatic logic [127:0] pack_state(input aes_state_t s);
        return 128'(s);
    endfunction

endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES round plus the matching key-schedule step; final_i drops MixColumns.
module aes_round_unit
    import aes_pkg::*;
(
    input  aes_state_t   state_i,
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    input  logic         final_i,
    output logic [127:0] rk_next_o,
    output aes_state_t   state_o
);

    logic [31:0] w0, w1, w2, w3, tmp;
    logic [31:0] n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_i;
    // RotWord then SubWord of the last word, rcon folded into the leading byte.
    assign tmp = {sub_byte(w3[23:16]) ^ rcon_i, sub_byte(w3[15:8]),
                  sub_byte(w3[7:0]), sub_byte(w3[31:24])};
    assign n0 = w0 ^ tmp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_next_o = {n0, n1, n2, n3};

    aes_state_t rk;
    logic [7:0] sr [4][4];
    logic [7:0] mc [4][4];

    assign rk = unpack_state(rk_next_o);

    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_sr
            // ShiftRows: row r of column c comes from column c+r.
            assign sr[c][r] = sub_byte(state_i[(c + r) % 4][r]);
        end

        assign mc[c][0] = xtime(sr[c][0]) ^ xtime(sr[c][1]) ^ sr[c][1] ^ sr[c][2] ^ sr[c][3];
        assign mc[c][1] = sr[c][0] ^ xtime(sr[c][1]) ^ xtime(sr[c][2]) ^ sr[c][2] ^ sr[c][3];
        assign mc[c][2] = sr[c][0] ^ sr[c][1] ^ xtime(sr[c][2]) ^ xtime(sr[c][3]) ^ sr[c][3];
        assign mc[c][3] = xtime(sr[c][0]) ^ sr[c][0] ^ sr[c][1] ^ sr[c][2] ^ xtime(sr[c][3]);

        for (genvar r = 0; r < 4; r++) begin : g_ark
            assign state_o[c][r] = (final_i ? sr[c][r] : mc[c][r]) ^ rk[c][r];
        end
    end

endmodule

// File: rtl/aes_iter_engine.sv
// Iterative AES-128 encryptor: one round per clock, round key expanded on the fly.
// Optional job abort and abort counter enabled by defining AES_ABORT_EN.
module aes_iter_engine
    import aes_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_plaintext,
    input  logic [127:0]     in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_ciphertext,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
`ifdef AES_ABORT_EN
    ,
    input  logic             abort,
    output logic [7:0]       abort_cnt
`endif
);

    aes_fsm_e         fsm_q;
    aes_state_t       state_q, state_d;
    logic [127:0]     key_q, rk_next_d;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       round_cnt_q;
    logic             out_valid_q;
    logic [127:0]     out_ct_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             abort_hit;

`ifdef AES_ABORT_EN
    logic [7:0] abort_cnt_q;
    assign abort_hit = abort && (fsm_q != ST_IDLE);
    assign abort_cnt = abort_cnt_q;
`else
    assign abort_hit = 1'b0;
`endif

    aes_round_unit u_round (
        .state_i   (state_q),
        .key_i     (key_q),
        .rcon_i    (rcon_of(round_cnt_q)),
        .final_i   (round_cnt_q == NR),
        .rk_next_o (rk_next_d),
        .state_o   (state_d)
    );

    assign in_ready       = (fsm_q == ST_IDLE);
    assign busy           = (fsm_q != ST_IDLE);
    assign out_valid      = out_valid_q;
    assign out_ciphertext = out_ct_q;
    assign out_tag        = out_tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            tag_q       <= '0;
            round_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_ct_q    <= '0;
            out_tag_q   <= '0;
`ifdef AES_ABORT_EN
            abort_cnt_q <= '0;
`endif
        end else if (abort_hit) begin
            // Abort beats round completion; any pending result is dropped.
            fsm_q       <= ST_IDLE;
            state_q     <= '0;
            key_q       <= '0;
            round_cnt_q <= '0;
            out_valid_q <= 1'b0;
`ifdef AES_ABORT_EN
            if (abort_cnt_q != 8'hff) abort_cnt_q <= abort_cnt_q + 8'd1;
`endif
        end else begin
            case (fsm_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q     <= unpack_state(in_plaintext ^ in_key);
                        key_q       <= in_key;
                        tag_q       <= in_tag;
                        round_cnt_q <= 4'd1;
                        fsm_q       <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    key_q   <= rk_next_d;
                    state_q <= state_d;
                    if (round_cnt_q == NR) begin
                        out_ct_q    <= pack_state(state_d);
                        out_tag_q   <= tag_q;
                        out_valid_q <= 1'b1;
                        fsm_q       <= ST_DONE;
                    end else begin
                        round_cnt_q <= round_cnt_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        round_cnt_q <= '0;
                        fsm_q       <= ST_IDLE;
                    end
                end
                default: fsm_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_iter_engine.sv
// Self-checking bench for aes_iter_engine: transaction-level reference AES plus per-cycle compare.
module tb_aes_iter_engine;

    localparam int TAG_W = 4;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [127:0]     in_plaintext = '0;
    logic [127:0]     in_key = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [127:0]     out_ciphertext;
    logic [TAG_W-1:0] out_tag;
    logic             busy;
`ifdef AES_ABORT_EN
    logic             abort = 1'b0;
    logic [7:0]       abort_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_iter_engine #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_plaintext   (in_plaintext),
        .in_key         (in_key),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ciphertext (out_ciphertext),
        .out_tag        (out_tag),
        .busy           (busy)
`ifdef AES_ABORT_EN
        ,
        .abort          (abort),
        .abort_cnt      (abort_cnt)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference AES (S-box derived from GF inverse + affine map)
    logic [7:0] sb [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            y = y >> 1;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] av = 8'(a);
            for (int b = 1; b < 256; b++)
                if (a != 0 && gmul(av, 8'(b)) == 8'h01) inv = 8'(b);
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0] w [44];
        logic [7:0]  s [16];
        logic [7:0]  t [16];
        logic [7:0]  rc = 8'h01;
        logic [31:0] tw;
        logic [127:0] ct;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i-1];
            if (i % 4 == 0) begin
                tw = {sb[tw[23:16]] ^ rc, sb[tw[15:8]], sb[tw[7:0]], sb[tw[31:24]]};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tw;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int k = 1; k <= 10; k++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[4*c + r] = (k == 10) ? t[4*c + r] :
                        gmul(t[4*c + r], 8'h02) ^ gmul(t[4*c + (r+1)%4], 8'h03) ^
                        t[4*c + (r+2)%4] ^ t[4*c + (r+3)%4];
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*k + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) ct[127 - 8*i -: 8] = s[i];
        return ct;
    endfunction

    // ---------------- transaction model: 0 idle, 1 computing, 2 result pending
    int               m_mode = 0;
    int               m_left = 0;
    int               m_handshakes = 0;
    logic [127:0]     m_exp = '0;
    logic [127:0]     m_ct = '0;
    logic [TAG_W-1:0] m_tag = '0;
    logic [TAG_W-1:0] m_otag = '0;
    int               m_abort = 0;
    bit               acc_now = 1'b0;
    int               edge_n = 0;
    int               acc_edges [$];

    initial forever begin
        @(posedge clk);
        edge_n++;
    end

    initial forever begin
        @(negedge clk);
        acc_now = 1'b0;
        if (!rst_n) begin
            m_mode = 0; m_ct = '0; m_otag = '0; m_abort = 0;
        end
        chk("in_ready", in_ready, m_mode == 0);
        chk("busy", busy, m_mode != 0);
        chk("out_valid", out_valid, m_mode == 2);
        chk("out_ciphertext", out_ciphertext, m_ct);
        chk("out_tag", out_tag, m_otag);
`ifdef AES_ABORT_EN
        chk("abort_cnt", abort_cnt, m_abort);
`endif
        if (rst_n) begin
`ifdef AES_ABORT_EN
            if (abort && m_mode != 0) begin
                m_mode = 0;
                if (m_abort < 255) m_abort++;
            end else
`endif
            if (m_mode == 0) begin
                if (in_valid) begin
                    acc_now = 1'b1;
                    acc_edges.push_back(edge_n + 1);
                    m_exp = aes_ref(in_plaintext, in_key);
                    m_tag = in_tag;
                    m_left = 10;
                    m_mode = 1;
                end
            end else if (m_mode == 1) begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 2; m_ct = m_exp; m_otag = m_tag;
                end
            end else if (out_ready) begin
                m_mode = 0;
                m_handshakes++;
            end
        end
    end

    // ---------------- driver tasks (called aligned to posedge + 2)
    task automatic offer(input logic [127:0] pt, input logic [127:0] key, input logic [TAG_W-1:0] tag);
        bit ok = 1'b0;
        in_valid = 1'b1; in_plaintext = pt; in_key = key; in_tag = tag;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (acc_now) begin ok = 1'b1; break; end
            @(posedge clk); #2;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (!out_valid) chk("valid_timeout", 0, 1);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e0;
        int sent;
        bit clr;
        bit rnd_done;
        int hs0;

        build_sbox();
        chk("sbox_00", sb[0], 8'h63);
        chk("sbox_53", sb[8'h53], 8'hed);
        chk("ref_appB", aes_ref(PT_B, KEY_B), CT_B);
        chk("ref_c1", aes_ref(PT_C, KEY_C), CT_C);

        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ct", out_ciphertext, 128'h0);
        rst_n = 1'b1;

        // FIPS-197 App. B with latency check
        out_ready = 1'b1;
        offer(PT_B, KEY_B, 4'd5);
        wait_valid(n);
        chk("appB_latency", n, 10);
        chk("appB_ct", out_ciphertext, CT_B);
        chk("appB_tag", out_tag, 4'd5);
        @(posedge clk); #2;
        chk("appB_released", out_valid, 1'b0);

        // C.1 followed by a back-to-back job
        e0 = acc_edges.size();
        offer(PT_C, KEY_C, 4'd2);
        offer(PT_C, KEY_C, 4'd9);
        chk("b2b_gap", acc_edges[e0+1] - acc_edges[e0], 12);
        wait_valid(n);
        chk("b2b_ct", out_ciphertext, CT_C);
        chk("b2b_tag", out_tag, 4'd9);
        @(posedge clk); #2;

        // back-pressure
        out_ready = 1'b0;
        offer(rnd128(), rnd128(), 4'd11);
        wait_valid(n);
        repeat (20) begin @(posedge clk); #2; end
        chk("bp_in_ready", in_ready, 1'b0);
        chk("bp_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #2;
        chk("bp_released", out_valid, 1'b0);
        chk("bp_idle", in_ready, 1'b1);

        // in_valid during ROUND must be ignored
        e0 = acc_edges.size();
        offer(PT_B, KEY_B, 4'd3);
        repeat (2) begin @(posedge clk); #2; end
        in_valid = 1'b1; in_plaintext = PT_C; in_key = KEY_C; in_tag = 4'd7;
        repeat (3) begin @(posedge clk); #2; end
        in_valid = 1'b0;
        offer(PT_C, KEY_C, 4'd10);
        chk("ignore_gap", acc_edges[e0+1] - acc_edges[e0], 12);
        wait_valid(n);
        chk("ignore_ct", out_ciphertext, CT_C);
        @(posedge clk); #2;

        // reset mid-job
        offer(rnd128(), rnd128(), 4'd1);
        repeat (4) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 1'b0);
        chk("midrst_ready", in_ready, 1'b1);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        offer(PT_C, KEY_C, 4'd6);
        wait_valid(n);
        chk("postrst_ct", out_ciphertext, CT_C);
        chk("postrst_tag", out_tag, 4'd6);
        @(posedge clk); #2;

`ifdef AES_ABORT_EN
        offer(rnd128(), rnd128(), 4'd4);
        repeat (2) begin @(posedge clk); #2; end
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        chk("abort_cnt_one", abort_cnt, 8'd1);
        chk("abort_ready", in_ready, 1'b1);
        chk("abort_valid", out_valid, 1'b0);
        offer(PT_B, KEY_B, 4'd5);
        wait_valid(n);
        chk("abort_follow_ct", out_ciphertext, CT_B);
        @(posedge clk); #2;
`endif

        // randomized jobs with random consumer back-pressure
        sent = 0; clr = 1'b0; rnd_done = 1'b0; hs0 = m_handshakes;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(posedge clk); #2;
            if (clr) begin in_valid = 1'b0; clr = 1'b0; end
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid && sent < 40 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b1;
                in_plaintext = rnd128();
                in_key = rnd128();
                in_tag = TAG_W'($urandom);
                sent++;
            end
            @(negedge clk); #1;
            if (acc_now) clr = 1'b1;
            if (sent == 40 && !in_valid && m_mode == 0) begin rnd_done = 1'b1; break; end
        end
        chk("random_done", rnd_done, 1'b1);
        chk("random_handshakes", m_handshakes - hs0, 40);

        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_iter_engine.md
Name: aes_iter_engine

Overview:
- Iterative AES-128 encryption engine. Executes one round per clock on a single shared round datapath instead of ten unrolled round instances.
- Expands the round key on the fly, one step per round; no 11-entry key store.
- Valid/ready on input (plaintext + key + tag) and output (ciphertext + tag).
- Sits between a host/DMA request port and a result consumer; area-reduced counterpart to the fully combinational encryptor.

Parameters:
- TAG_W, 4, width of opaque job tag returned unchanged with the ciphertext.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  job offered.
- in_ready  out  1  engine can accept a job.
- in_plaintext  in  128  plaintext; byte 0 at [127:120], column-major state.
- in_key  in  128  cipher key, same byte order.
- in_tag  in  TAG_W  job tag.
- out_valid  out  1  ciphertext available.
- out_ready  in  1  consumer accepts.
- out_ciphertext  out  128  result, same byte order.
- out_tag  out  TAG_W  tag of completed job.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert by the system): state=IDLE; in_ready=1, out_valid=0, busy=0, out_ciphertext=0, out_tag=0, round_cnt=0; internal state and key registers cleared.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: state_reg<=plaintext^key (round-0 AddRoundKey), key_reg<=key, tag_reg<=tag, round_cnt<=1, go to ROUND.
- ROUND:
  - in_ready=0.
  - Each cycle: rk_next = KeyExpandStep(key_reg, RCON[round_cnt]); key_reg<=rk_next.
  - round_cnt 1..9: state_reg<=AddRoundKey(MixColumns(ShiftRows(SubBytes(state_reg))), rk_next).
  - round_cnt==10: MixColumns omitted; result loads out_ciphertext/out_tag; out_valid<=1; go to DONE.
  - round_cnt increments by 1 per cycle; range 0..10, never wraps.
- DONE:
  - out_valid=1; out_ciphertext/out_tag held stable until the handshake completes.
  - in_ready=0.
  - On out_ready: out_valid<=0, go to IDLE.
- Latency: accept edge at cycle T; out_valid rises after edge T+10; earliest next accept at edge T+12 with out_ready held high. Throughput 1 block per 12 cycles.
- Back-pressure: out_ready low holds DONE indefinitely; outputs must not change.
- out_ready asserted while out_valid=0: ignored.
- in_valid asserted in ROUND/DONE: ignored, not latched. The source must hold the request until in_ready.
- Reset asserted mid-job: job discarded, no output produced, all outputs return to reset values immediately.
- RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.

Optional Feature:
- Macro AES_ABORT_EN.
- When defined:
  - Adds input abort (1 bit).
  - abort high in ROUND: next edge goes to IDLE; state/key registers cleared; out_valid stays 0; no output for that job.
  - abort in IDLE: no effect.
  - abort in DONE: clears out_valid and returns to IDLE; result dropped.
  - abort has priority over round completion in the same cycle.
  - Adds output abort_cnt (8 bits), saturating count of aborted jobs; reset 0.
- When undefined: no abort/abort_cnt ports; FSM exactly as above.

Decomposition:
- Package aes_pkg:
  - SBOX constant array and sub_byte function.
  - RCON table.
  - xtime/GF mult-by-2 function.
  - state typedef (4x4 bytes) with pack/unpack functions for the 128-bit byte order.
  - FSM enum typedef.
- Sub-module aes_round_unit (combinational):
  - Inputs: state, round key, final_round flag.
  - Output: next state.
  - Also hosts KeyExpandStep(key, rcon) returning rk_next.
- aes_iter_engine holds only the FSM, registers and handshake.

Test Plan:
- FIPS-197 App. B: pt=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c, tag=5 -> ciphertext=3925841d02dc09fbdc118597196a0b32, tag=5, out_valid exactly 10 edges after accept.
- FIPS-197 C.1: pt=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> 69c4e0d86a7b0430d8cdb78070b4c55a; then a second job issued back-to-back -> accepted at the T+12 edge, correct result.
- Back-pressure: out_ready=0 for 20 cycles after out_valid -> outputs stable, in_ready=0; out_ready=1 -> single handshake, back to IDLE.
- Ignored input: in_valid pulses with a different pt during ROUND -> result still matches the first job; the second job is accepted only after DONE.
- Reset mid-job: rst_n low at round 5 -> out_valid=0, in_ready=1 after release; new C.1 job completes correctly.
- AES_ABORT_EN: abort at round_cnt=3 -> no out_valid, abort_cnt=1, in_ready=1 next cycle; follow-on App. B job correct.
